inst_ident_scan: RTL and testbench

Parametrised instance-identity reporter for the hierarchy-identity test suite. Given a parent index, it derives and serially emits one identity record per child channel: child index `FANOUT*parent_idx + ch`, plus a per-channel parameter pair. Records leave through a valid/ready stream for a checker or logger. One scan is started by a `start` pulse and finishes with a `done` pulse. It replaces fixed two-child, display-only identity checks with a synthesizable, backpressure-aware block of configurable fan-out and width.

---
 rtl/inst_ident_scan.sv | 105 ++++++++++
 tb/tb_inst_ident_scan.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_ident_scan.sv
// inst_ident_scan: serial per-channel identity record emitter.
// Ports: clk, rst, start, parent_idx -> busy, out_* stream, done.
module inst_ident_scan #(
    parameter int IDX_W   = 32,
    parameter int P_W     = 32,
    parameter int FANOUT  = 2,
    parameter int P_BASE  = 500,
    parameter int REVERSE = 0,
    localparam int CH_W   = (FANOUT > 2) ? $clog2(FANOUT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] parent_idx,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_chan,
    output logic [IDX_W-1:0] out_idx,
    output logic [P_W-1:0]   out_p1,
    output logic [P_W-1:0]   out_p2,
    output logic             out_last,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

    localparam logic [CH_W-1:0] CH_HI    = CH_W'(FANOUT - 1);
    localparam logic [CH_W-1:0] CH_FIRST = (REVERSE != 0) ? CH_HI : '0;
    localparam logic [CH_W-1:0] CH_LAST  = (REVERSE != 0) ? '0 : CH_HI;

    state_t           state;
    logic [IDX_W-1:0] parent_q;
    logic [IDX_W-1:0] load_p;
    logic [CH_W-1:0]  load_c;
    logic [CH_W-1:0]  ch_step;
    logic [P_W-1:0]   p1_next;

    // Record fields are precomputed for whichever channel is loaded next,
    // so every output comes straight from a register.
    always_comb begin
        ch_step = (REVERSE != 0) ? out_chan - 1'b1 : out_chan + 1'b1;
        load_p  = parent_q;
        load_c  = ch_step;
        if (state == IDLE) begin
            load_p = parent_idx;
            load_c = CH_FIRST;
        end
        p1_next = P_W'(P_BASE) + (P_W'(load_c) << 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            parent_q  <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_chan  <= '0;
            out_idx   <= '0;
            out_p1    <= '0;
            out_p2    <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        parent_q  <= parent_idx;
                        out_chan  <= load_c;
                        out_idx   <= IDX_W'(FANOUT) * load_p + IDX_W'(load_c);
                        out_p1    <= p1_next;
                        out_p2    <= p1_next + P_W'(1);
                        out_last  <= (load_c == CH_LAST);
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            out_chan <= load_c;
                            out_idx  <= IDX_W'(FANOUT) * load_p + IDX_W'(load_c);
                            out_p1   <= p1_next;
                            out_p2   <= p1_next + P_W'(1);
                            out_last <= (load_c == CH_LAST);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_ident_scan.sv
// tb_inst_ident_scan: directed checks of inst_ident_scan.
// Three instances: default, IDX_W=8/FANOUT=4, FANOUT=4/REVERSE=1.
module tb_inst_ident_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // u0: defaults (FANOUT=2, IDX_W=32)
    logic        start0 = 0, ready0 = 0;
    logic [31:0] par0 = '0;
    logic        busy0, v0, last0, done0;
    logic [0:0]  ch0;
    logic [31:0] idx0, p10, p20;

    // u1: IDX_W=8, FANOUT=4
    logic        start1 = 0, ready1 = 0;
    logic [7:0]  par1 = '0;
    logic        busy1, v1, last1, done1;
    logic [1:0]  ch1;
    logic [7:0]  idx1;
    logic [31:0] p11, p21;

    // u2: FANOUT=4, REVERSE=1
    logic        start2 = 0, ready2 = 0;
    logic [31:0] par2 = '0;
    logic        busy2, v2, last2, done2;
    logic [1:0]  ch2;
    logic [31:0] idx2, p12, p22;

    inst_ident_scan u0 (
        .clk(clk), .rst(rst), .start(start0), .parent_idx(par0),
        .busy(busy0), .out_valid(v0), .out_ready(ready0),
        .out_chan(ch0), .out_idx(idx0), .out_p1(p10), .out_p2(p20),
        .out_last(last0), .done(done0)
    );

    inst_ident_scan #(.IDX_W(8), .FANOUT(4)) u1 (
        .clk(clk), .rst(rst), .start(start1), .parent_idx(par1),
        .busy(busy1), .out_valid(v1), .out_ready(ready1),
        .out_chan(ch1), .out_idx(idx1), .out_p1(p11), .out_p2(p21),
        .out_last(last1), .done(done1)
    );

    inst_ident_scan #(.FANOUT(4), .REVERSE(1)) u2 (
        .clk(clk), .rst(rst), .start(start2), .parent_idx(par2),
        .busy(busy2), .out_valid(v2), .out_ready(ready2),
        .out_chan(ch2), .out_idx(idx2), .out_p1(p12), .out_p2(p22),
        .out_last(last2), .done(done2)
    );

    int total = 0;
    int passed = 0;
    int xfer0 = 0;
    int dcnt1 = 0;
    int base;

    always @(posedge clk) begin
        if (v0 && ready0) xfer0 <= xfer0 + 1;
        if (done1) dcnt1 <= dcnt1 + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rec0(input string tag, input int c, input int i,
                        input int l);
        chk({tag, ".valid"}, 64'(v0), 64'd1);
        chk({tag, ".chan"}, 64'(ch0), 64'(c));
        chk({tag, ".idx"}, 64'(idx0), 64'(i));
        chk({tag, ".p1"}, 64'(p10), 64'(500 + 2 * c));
        chk({tag, ".p2"}, 64'(p20), 64'(501 + 2 * c));
        chk({tag, ".last"}, 64'(last0), 64'(l));
    endtask

    task automatic rec1(input string tag, input int c, input int i);
        chk({tag, ".valid"}, 64'(v1), 64'd1);
        chk({tag, ".chan"}, 64'(ch1), 64'(c));
        chk({tag, ".idx"}, 64'(idx1), 64'(i));
        chk({tag, ".p1"}, 64'(p11), 64'(500 + 2 * c));
        chk({tag, ".p2"}, 64'(p21), 64'(501 + 2 * c));
        chk({tag, ".last"}, 64'(last1), 64'(c == 3));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        #3;
        chk("rst.u0", {busy0, v0, 1'(ch0), idx0, last0, done0}, 64'd0);
        chk("rst.u0.p", {p10, p20}, 64'd0);
        chk("rst.u1", {busy1, v1, ch1, idx1, last1, done1}, 64'd0);
        chk("rst.u2", {busy2, v2, ch2, idx2, last2, done2}, 64'd0);
        #4 rst = 0;
        step();
        chk("idle.valid", 64'(v0), 64'd0);

        // basic scan, parent 3
        start0 = 1; par0 = 3; ready0 = 1;
        step();
        start0 = 0;
        chk("basic.busy", 64'(busy0), 64'd1);
        rec0("basic.r0", 0, 6, 0);
        step();
        rec0("basic.r1", 1, 7, 1);
        chk("basic.done_early", 64'(done0), 64'd0);
        step();
        chk("basic.done", 64'(done0), 64'd1);
        chk("basic.valid_off", 64'(v0), 64'd0);
        chk("basic.busy_done", 64'(busy0), 64'd1);
        step();
        chk("basic.done_pulse", 64'(done0), 64'd0);
        chk("basic.busy_off", 64'(busy0), 64'd0);

        // backpressure, parent 5
        base = xfer0;
        ready0 = 0; start0 = 1; par0 = 5;
        step();
        start0 = 0;
        for (int k = 0; k < 3; k++) begin
            rec0($sformatf("bp.hold%0d", k), 0, 10, 0);
            step();
        end
        rec0("bp.hold3", 0, 10, 0);
        ready0 = 1;
        step();
        ready0 = 0;
        rec0("bp.r1", 1, 11, 1);
        step();
        rec0("bp.r1hold", 1, 11, 1);
        ready0 = 1;
        step();
        chk("bp.done", 64'(done0), 64'd1);
        chk("bp.xfers", 64'(xfer0 - base), 64'd2);
        step();

        // ignored start during scan of parent 3
        start0 = 1; par0 = 3;
        step();
        start0 = 1; par0 = 9;
        rec0("ign.r0", 0, 6, 0);
        step();
        rec0("ign.r1", 1, 7, 1);
        step();
        start0 = 0;
        chk("ign.done", 64'(done0), 64'd1);
        step();
        step();
        chk("ign.no_rescan", 64'(v0), 64'd0);
        chk("ign.idle", 64'(busy0), 64'd0);

        // wrap: IDX_W=8, FANOUT=4, parent 70 -> base 24
        start1 = 1; par1 = 70; ready1 = 1;
        step();
        start1 = 0;
        for (int k = 0; k < 4; k++) begin
            rec1($sformatf("wrap.r%0d", k), k, 24 + k);
            step();
        end
        chk("wrap.done", 64'(done1), 64'd1);
        step();

        // reverse: FANOUT=4, parent 1
        start2 = 1; par2 = 1; ready2 = 1;
        step();
        start2 = 0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rev.chan%0d", k), 64'(ch2), 64'(3 - k));
            chk($sformatf("rev.idx%0d", k), 64'(idx2), 64'(7 - k));
            chk($sformatf("rev.p1_%0d", k), 64'(p12), 64'(506 - 2 * k));
            chk($sformatf("rev.last%0d", k), 64'(last2), 64'(k == 3));
            step();
        end
        chk("rev.done", 64'(done2), 64'd1);
        step();

        // reset during record 1 of 4
        base = dcnt1;
        start1 = 1; par1 = 7;
        step();
        start1 = 0;
        rec1("mid.r0", 0, 28);
        step();
        rec1("mid.r1", 1, 29);
        #2 rst = 1;
        #1;
        chk("mid.rst_outs", {busy1, v1, ch1, idx1, last1, done1}, 64'd0);
        chk("mid.rst_p", {p11, p21}, 64'd0);
        step();
        rst = 0;
        step();
        step();
        chk("mid.no_done", 64'(dcnt1 - base), 64'd0);
        chk("mid.idle", 64'(v1), 64'd0);
        start1 = 1; par1 = 2;
        step();
        start1 = 0;
        for (int k = 0; k < 4; k++) begin
            rec1($sformatf("post.r%0d", k), k, 8 + k);
            step();
        end
        chk("post.done", 64'(done1), 64'd1);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
